// File: rtl/mux_sched_pkg.sv
// Shared types and defaults for the two-lane output scheduler.
// Build option: MUX_SCHED_STRICT_ALT_EN selects strict lane alternation.
package mux_sched_pkg;

    localparam int DATA_W_DEF = 4;
    localparam int CNT_W_DEF  = 8;

    typedef enum logic {
        LANE0 = 1'b0,
        LANE1 = 1'b1
    } lane_t;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } ostate_t;

    function automatic lane_t other_lane(lane_t l);
        return (l == LANE0) ? LANE1 : LANE0;
    endfunction

endpackage

// File: rtl/mux_sched_sat_cnt.sv
// Saturating up-counter with a synchronous clear that beats increment.
// Used for the per-lane grant counts in mux_sched.
module sat_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    logic at_max;

    assign at_max = (cnt == {CNT_W{1'b1}});

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !at_max) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mux_sched.sv
// Two-lane round-robin scheduler feeding one registered valid/ready stage.
// Define MUX_SCHED_STRICT_ALT_EN for strict alternation (no work conservation).
module mux_sched
    import mux_sched_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in0_valid,
    input  logic [DATA_W-1:0] in0_data,
    output logic              in0_ready,
    input  logic              in1_valid,
    input  logic [DATA_W-1:0] in1_data,
    output logic              in1_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_lane,
    input  logic              out_ready,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  grant_cnt0,
    output logic [CNT_W-1:0]  grant_cnt1
);

    ostate_t           state;
    ostate_t           state_nxt;
    lane_t             last_lane;
    lane_t             out_lane_q;
    lane_t             gnt_lane;
    logic              gnt_vld;
    logic              load_en;
    logic [DATA_W-1:0] gnt_data;

    // Single-entry stage: a beat may load while the held one drains.
    assign load_en = !out_valid || out_ready;

`ifdef MUX_SCHED_STRICT_ALT_EN
    always_comb begin
        gnt_vld  = 1'b0;
        gnt_lane = other_lane(last_lane);
        if (load_en) begin
            gnt_vld = (gnt_lane == LANE0) ? in0_valid : in1_valid;
        end
    end
`else
    logic both_v;
    logic only0_v;
    logic only1_v;

    assign both_v  = in0_valid && in1_valid;
    assign only0_v = in0_valid && !in1_valid;
    assign only1_v = !in0_valid && in1_valid;

    always_comb begin
        gnt_vld  = 1'b0;
        gnt_lane = LANE0;
        if (load_en) begin
            unique case (1'b1)
                both_v: begin
                    gnt_vld  = 1'b1;
                    gnt_lane = other_lane(last_lane);
                end
                only0_v: begin
                    gnt_vld  = 1'b1;
                    gnt_lane = LANE0;
                end
                only1_v: begin
                    gnt_vld  = 1'b1;
                    gnt_lane = LANE1;
                end
                default: begin
                    gnt_vld  = 1'b0;
                    gnt_lane = LANE0;
                end
            endcase
        end
    end
`endif

    assign gnt_data = (gnt_lane == LANE0) ? in0_data : in1_data;

    // Readies are held low while reset is asserted.
    assign in0_ready = !reset && gnt_vld && (gnt_lane == LANE0);
    assign in1_ready = !reset && gnt_vld && (gnt_lane == LANE1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            EMPTY: begin
                if (gnt_vld) begin
                    state_nxt = FULL;
                end
            end
            FULL: begin
                if (gnt_vld) begin
                    state_nxt = FULL;
                end else if (out_ready) begin
                    state_nxt = EMPTY;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    always_comb begin
        out_valid = (state == FULL);
        out_lane  = out_lane_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_data   <= '0;
            out_lane_q <= LANE0;
            last_lane  <= LANE1;
        end else if (gnt_vld) begin
            out_data   <= gnt_data;
            out_lane_q <= gnt_lane;
            last_lane  <= gnt_lane;
        end
    end

    sat_cnt #(
        .CNT_W (CNT_W)
    ) u_cnt0 (
        .clk   (clk),
        .reset (reset),
        .inc   (gnt_vld && (gnt_lane == LANE0)),
        .clr   (cnt_clr),
        .cnt   (grant_cnt0)
    );

    sat_cnt #(
        .CNT_W (CNT_W)
    ) u_cnt1 (
        .clk   (clk),
        .reset (reset),
        .inc   (gnt_vld && (gnt_lane == LANE1)),
        .clr   (cnt_clr),
        .cnt   (grant_cnt1)
    );

endmodule

// File: doc/mux_sched.md
# mux_sched

Two-lane scheduler for the shared 4-bit output path. Two requesters present 4-bit beats with valid/ready handshakes. The block arbitrates round-robin between them and drives a single registered output stage with valid/ready and a lane tag. Per-lane saturating grant counters support bandwidth checks. It replaces the free-running alternate-every-cycle selector with a handshake-aware, fair sequencer.

## Interface
- DATA_W, 4, beat width
- CNT_W, 8, grant counter width
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- in0_valid  input  1  lane 0 beat present
- in0_data  input  DATA_W  lane 0 beat
- in0_ready  output  1  lane 0 beat accepted this cycle when high with in0_valid
- in1_valid, in1_data, in1_ready  same as lane 0, for lane 1
- out_valid  output  1  output register holds a beat
- out_data  output  DATA_W  registered beat
- out_lane  output  1  source lane of out_data
- out_ready  input  1  downstream accepts out_data when high with out_valid
- cnt_clr  input  1  synchronous clear of both grant counters
- grant_cnt0, grant_cnt1  output  CNT_W  saturating grant counts per lane

## Operation
- Output stage state: EMPTY (out_valid=0) / FULL (out_valid=1).
- load_en = !out_valid | out_ready. This is a single-register pipeline, so a new beat loads in the same cycle the old one drains.
- Grant, when load_en is high:
  - Both valid: grant the lane != last_lane.
  - One valid: grant that lane (work-conserving).
  - None valid: no grant.
- inK_ready = load_en & (grant==K). Ready may depend combinationally on both valids and out_ready. Ready never depends on its own lane's data.
- On grant:
  - out_data <= granted data.
  - out_lane <= K.
  - out_valid <= 1.
  - last_lane <= K.
  - grant_cntK increments, saturating at 2^CNT_W-1.
- No grant and out_ready high: out_valid <= 0.
- out_valid high and out_ready low: out_data and out_lane hold stable.
- cnt_clr: both counters go to 0 next cycle. Clear wins over a same-cycle grant, so the result is 0, not 1.
- Counters hold at all-ones once saturated. They do not wrap.

## Timing
- Reset values:
  - out_valid=0, out_data=0, out_lane=0.
  - grant_cnt0=grant_cnt1=0.
  - last_lane=1, so lane 0 wins the first contention.
  - in0_ready/in1_ready are 0 while reset is asserted.
- Latency: an accepted beat appears on out_* the cycle after the handshake.
- Throughput: 1 beat/cycle with out_ready held high. Under continuous contention, lanes alternate 0,1,0,1.
- Reset asserted mid-operation: outputs clear immediately, without waiting for a clock edge. A beat held in the output register is discarded.
- First grant after deassertion happens at the first clk edge with reset low.

## Configuration
- MUX_SCHED_STRICT_ALT_EN
- Defined: strict alternation. Only lane next=!last_lane may be granted. An idle lane stalls the other, with no work conservation. last_lane toggles only on grant.
- Undefined: work-conserving round-robin as in Operation.

## Structure
- Shared package mux_sched_pkg holds:
  - Default DATA_W and CNT_W localparams.
  - lane_t enum: LANE0=0, LANE1=1.
- Sub-module sat_cnt (parameter CNT_W; inputs inc and clr, clr priority; output cnt) is instantiated twice for the grant counters.
- Arbitration and the output register stay in mux_sched.

## Test plan
- Reset, then in0_valid=1 with data 4'hA and in1_valid=0, out_ready=1 -> in0_ready=1. Next cycle out_valid=1, out_data=A, out_lane=0, grant_cnt0=1.
- Both lanes valid continuously (lane0=3, lane1=C), out_ready=1 -> output sequence 3,C,3,C with lanes 0,1,0,1. Both counters advance equally.
- out_valid=1, out_ready=0 for 5 cycles with both lanes valid -> both inK_ready=0 and out_data stable. On release, the next beat loads in the same cycle.
- Only lane 1 valid for 4 cycles -> 4 lane-1 beats (work-conserving). With MUX_SCHED_STRICT_ALT_EN defined -> 1 beat, then a stall until lane 0 becomes valid.
- Hold lane 0 valid with CNT_W=4 for 20 grants -> grant_cnt0 stops at 15. Pulse cnt_clr on a grant cycle -> count becomes 0.
- Assert reset mid-stream with out_valid=1 -> out_valid=0 before the next edge. After release, lane 0 wins first contention.
